// File: rtl/sdhci_cmd_rsp_rx_if.sv
// Control/status bundle between the CMD response receiver and the register file / issue sequencer.
// Signal suffixes are from the receiver's point of view.
interface sdhci_cmd_rsp_rx_if #(
    parameter int RspWidth = 120
);
    logic                sd_clk_en_i;
    logic                sd_cmd_i;
    logic                start_i;
    logic                long_i;
    logic [5:0]          exp_index_i;
    logic                check_index_i;
    logic                check_crc_i;
    logic                abort_i;
    logic                busy_o;
    logic                done_o;
    logic [RspWidth-1:0] response_o;
    logic                timeout_err_o;
    logic                crc_err_o;
    logic                index_err_o;
    logic                end_bit_err_o;

    modport master (
        output sd_clk_en_i, sd_cmd_i, start_i, long_i, exp_index_i,
               check_index_i, check_crc_i, abort_i,
        input  busy_o, done_o, response_o, timeout_err_o, crc_err_o,
               index_err_o, end_bit_err_o
    );

    modport slave (
        input  sd_clk_en_i, sd_cmd_i, start_i, long_i, exp_index_i,
               check_index_i, check_crc_i, abort_i,
        output busy_o, done_o, response_o, timeout_err_o, crc_err_o,
               index_err_o, end_bit_err_o
    );
endinterface

// File: rtl/sdhci_cmd_rsp_rx.sv
// SD CMD-line response receiver: deserialises 48-bit or 136-bit (R2) responses,
// checks framing/index/CRC7 and enforces the Ncr start-bit timeout.
module sdhci_cmd_rsp_rx #(
    parameter int TimeoutSdClks = 64,
    parameter int RspWidth      = 120
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    sdhci_cmd_rsp_rx_if.slave bus
);
    localparam int LenShort = 48;
    localparam int LenLong  = 136;
    localparam int CntMax   = (TimeoutSdClks > LenLong) ? TimeoutSdClks : LenLong;
    localparam int CntW     = $clog2(CntMax + 1);

    typedef enum logic [1:0] {IDLE, WAIT_START, RECV, DONE} state_e;

    state_e              state_q, state_d;
    logic                long_q, long_d;
    logic [5:0]          exp_idx_q, exp_idx_d;
    logic                chk_idx_q, chk_idx_d;
    logic                chk_crc_q, chk_crc_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [RspWidth-1:0] sr_q, sr_d;
    logic [5:0]          idx_q, idx_d;
    logic [6:0]          rcrc_q, rcrc_d;
    logic [6:0]          crc_q, crc_d;
    logic                trans_q, trans_d;
    logic [RspWidth-1:0] rsp_q, rsp_d;
    logic                tmo_err_q, tmo_err_d;
    logic                crc_err_q, crc_err_d;
    logic                idx_err_q, idx_err_d;
    logic                end_err_q, end_err_d;

    logic                strobe;
    logic                bit_in;
    logic                crc_fb;
    logic                tmo_last;
    logic [CntW-1:0]     len_m1;
    logic [CntW-1:0]     crc_first;

    assign strobe    = bus.sd_clk_en_i;
    assign bit_in    = bus.sd_cmd_i;
    assign crc_fb    = bit_in ^ crc_q[6];
    assign tmo_last  = (cnt_q == CntW'(TimeoutSdClks - 1));
    assign len_m1    = long_q ? CntW'(LenLong - 1) : CntW'(LenShort - 1);
    // A zero start bit leaves a zero CRC unchanged, so short frames can begin at the transmission bit.
    assign crc_first = long_q ? CntW'(8) : CntW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.abort_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:       if (bus.start_i) state_d = WAIT_START;
                WAIT_START: if (strobe) begin
                    if (!bit_in)       state_d = RECV;
                    else if (tmo_last) state_d = DONE;
                end
                RECV:       if (strobe && cnt_q == len_m1) state_d = DONE;
                DONE:       state_d = IDLE;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        long_d    = long_q;
        exp_idx_d = exp_idx_q;
        chk_idx_d = chk_idx_q;
        chk_crc_d = chk_crc_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        idx_d     = idx_q;
        rcrc_d    = rcrc_q;
        crc_d     = crc_q;
        trans_d   = trans_q;
        rsp_d     = rsp_q;
        tmo_err_d = tmo_err_q;
        crc_err_d = crc_err_q;
        idx_err_d = idx_err_q;
        end_err_d = end_err_q;
        if (!bus.abort_i) begin
            unique case (state_q)
                IDLE: if (bus.start_i) begin
                    long_d    = bus.long_i;
                    exp_idx_d = bus.exp_index_i;
                    chk_idx_d = bus.check_index_i;
                    chk_crc_d = bus.check_crc_i;
                    cnt_d     = '0;
                    sr_d      = '0;
                    idx_d     = '0;
                    rcrc_d    = '0;
                    crc_d     = '0;
                    trans_d   = 1'b0;
                    rsp_d     = '0;
                    tmo_err_d = 1'b0;
                    crc_err_d = 1'b0;
                    idx_err_d = 1'b0;
                    end_err_d = 1'b0;
                end
                WAIT_START: if (strobe) begin
                    if (!bit_in)       cnt_d = CntW'(1);
                    else if (tmo_last) tmo_err_d = 1'b1;
                    else               cnt_d = cnt_q + CntW'(1);
                end
                RECV: if (strobe) begin
                    // cnt_q is the position of the incoming bit counted from the start bit.
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(1)) trans_d = bit_in;
                    if (cnt_q >= CntW'(2) && cnt_q <= CntW'(7)) idx_d = {idx_q[4:0], bit_in};
                    if (cnt_q >= CntW'(8) && cnt_q <= len_m1 - CntW'(8)) sr_d = {sr_q[RspWidth-2:0], bit_in};
                    if (cnt_q >= crc_first && cnt_q <= len_m1 - CntW'(8))
                        crc_d = {crc_q[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
                    if (cnt_q > len_m1 - CntW'(8) && cnt_q < len_m1) rcrc_d = {rcrc_q[5:0], bit_in};
                    if (cnt_q == len_m1) begin
                        rsp_d     = sr_q;
                        end_err_d = !bit_in || trans_q;
                        crc_err_d = chk_crc_q && (crc_q != rcrc_q);
                        idx_err_d = chk_idx_q && !long_q && (idx_q != exp_idx_q);
                    end
                end
                DONE:    ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            long_q    <= 1'b0;
            exp_idx_q <= '0;
            chk_idx_q <= 1'b0;
            chk_crc_q <= 1'b0;
            cnt_q     <= '0;
            sr_q      <= '0;
            idx_q     <= '0;
            rcrc_q    <= '0;
            crc_q     <= '0;
            trans_q   <= 1'b0;
            rsp_q     <= '0;
            tmo_err_q <= 1'b0;
            crc_err_q <= 1'b0;
            idx_err_q <= 1'b0;
            end_err_q <= 1'b0;
        end else begin
            long_q    <= long_d;
            exp_idx_q <= exp_idx_d;
            chk_idx_q <= chk_idx_d;
            chk_crc_q <= chk_crc_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            idx_q     <= idx_d;
            rcrc_q    <= rcrc_d;
            crc_q     <= crc_d;
            trans_q   <= trans_d;
            rsp_q     <= rsp_d;
            tmo_err_q <= tmo_err_d;
            crc_err_q <= crc_err_d;
            idx_err_q <= idx_err_d;
            end_err_q <= end_err_d;
        end
    end

    always_comb begin
        bus.busy_o        = (state_q == WAIT_START) || (state_q == RECV);
        bus.done_o        = (state_q == DONE);
        bus.response_o    = rsp_q;
        bus.timeout_err_o = tmo_err_q;
        bus.crc_err_o     = crc_err_q;
        bus.index_err_o   = idx_err_q;
        bus.end_bit_err_o = end_err_q;
    end
endmodule

// File: tb/tb_sdhci_cmd_rsp_rx.sv
// Randomised bench for sdhci_cmd_rsp_rx against a frame-level reference model
// (CRC7 by polynomial long division, fields sliced from the whole frame).
module tb_sdhci_cmd_rsp_rx;
    localparam int Tmo = 64;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    sdhci_cmd_rsp_rx_if #(.RspWidth(120)) bus ();

    sdhci_cmd_rsp_rx #(.TimeoutSdClks(Tmo), .RspWidth(120)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] outs();
        return {4'b0, bus.response_o, bus.timeout_err_o, bus.crc_err_o, bus.index_err_o, bus.end_bit_err_o};
    endfunction

    // Remainder of msg(x) * x^7 divided by x^7 + x^3 + 1, msg = low n bits, MSB first.
    function automatic logic [6:0] crc7_ref(input logic [135:0] msg, input int n);
        logic [142:0] d;
        d = {7'b0, msg} << 7;
        for (int i = n + 6; i >= 7; i--)
            if (d[i]) d[i -: 8] = d[i -: 8] ^ 8'h89;
        return d[6:0];
    endfunction

    function automatic logic [135:0] make_frame(input bit lng, input logic [5:0] idx, input logic [119:0] content,
                                                input bit trans, input bit endb, input int crc_ov);
        logic [135:0] f;
        logic [6:0]   c;
        f = '0;
        if (lng) begin
            f = {1'b0, trans, 6'h3F, content, 7'h00, endb};
            c = crc7_ref(136'(f[127:8]), 120);
        end else begin
            f[47:0] = {1'b0, trans, idx, content[31:0], 7'h00, endb};
            c = crc7_ref(136'(f[47:8]), 40);
        end
        f[7:1] = (crc_ov >= 0) ? crc_ov[6:0] : c;
        return f;
    endfunction

    function automatic logic [127:0] expect_outs(input bit lng, input logic [135:0] f, input logic [5:0] expi,
                                                 input bit ci, input bit cc, input int idle);
        logic [119:0] rsp;
        logic [6:0]   calc;
        bit           e_crc, e_idx, e_end;
        if (idle >= Tmo) return {4'b0, 120'b0, 4'b1000};
        if (lng) begin
            rsp   = f[127:8];
            calc  = crc7_ref(136'(f[127:8]), 120);
            e_idx = 1'b0;
            e_end = !f[0] || f[134];
        end else begin
            rsp   = {88'b0, f[39:8]};
            calc  = crc7_ref(136'(f[47:8]), 40);
            e_idx = ci && (f[45:40] != expi);
            e_end = !f[0] || f[46];
        end
        e_crc = cc && (f[7:1] != calc);
        return {4'b0, rsp, 1'b0, e_crc, e_idx, e_end};
    endfunction

    task automatic run_frame(input string tag, input bit lng, input logic [135:0] f, input logic [5:0] expi,
                             input bit ci, input bit cc, input int idle, input bit stuck,
                             input int abort_at, input int rst_at, input bit noise);
        int           len, total, k, cyc;
        bit           en, early;
        logic [127:0] exp_o;
        len   = lng ? 136 : 48;
        total = (idle >= Tmo) ? Tmo : idle + len;
        exp_o = expect_outs(lng, f, expi, ci, cc, idle);
        bus.start_i       = 1'b1;
        bus.long_i        = lng;
        bus.exp_index_i   = expi;
        bus.check_index_i = ci;
        bus.check_crc_i   = cc;
        bus.sd_clk_en_i   = 1'($urandom);
        bus.sd_cmd_i      = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check_val({tag, " busy"}, 128'(bus.busy_o), 128'd1);
        check_val({tag, " clear"}, outs(), 128'd0);
        k = 0; cyc = 0; early = 1'b0;
        while (k < total) begin
            en = stuck ? 1'b1 : 1'($urandom_range(0, 1));
            bus.sd_clk_en_i = en;
            if (en) bus.sd_cmd_i = (k < idle) ? 1'b1 : f[len-1-(k-idle)];
            else    bus.sd_cmd_i = 1'($urandom);
            bus.abort_i = en && (abort_at >= 0) && (k - idle == abort_at);
            if (noise) begin
                bus.start_i     = 1'($urandom);
                bus.long_i      = 1'($urandom);
                bus.exp_index_i = 6'($urandom);
                bus.check_crc_i = 1'($urandom);
            end
            tick();
            cyc++;
            if (en) k++;
            if (bus.abort_i) begin
                bus.abort_i = 1'b0;
                bus.start_i = 1'b0;
                check_val({tag, " busy after abort"}, 128'(bus.busy_o), 128'd0);
                check_val({tag, " outs after abort"}, outs(), 128'd0);
                for (int i = 0; i < 4; i++) begin
                    if (bus.done_o) early = 1'b1;
                    tick();
                end
                check_val({tag, " no done after abort"}, 128'(early), 128'd0);
                return;
            end
            if (en && rst_at >= 0 && k - idle == rst_at) begin
                rst_ni = 1'b0;
                #1;
                check_val({tag, " outs in reset"}, outs(), 128'd0);
                check_val({tag, " busy/done in reset"}, 128'({bus.busy_o, bus.done_o}), 128'd0);
                tick();
                rst_ni = 1'b1;
                tick();
                return;
            end
            if (k < total && bus.done_o) early = 1'b1;
            if (cyc > 4000) begin
                check_val({tag, " cycle budget"}, 128'(cyc), 128'd4000);
                break;
            end
        end
        bus.sd_clk_en_i = 1'b0;
        bus.start_i     = 1'b0;
        bus.abort_i     = 1'b0;
        check_val({tag, " early done"}, 128'(early), 128'd0);
        check_val({tag, " done latency"}, 128'(bus.done_o), 128'd1);
        check_val({tag, " busy in done"}, 128'(bus.busy_o), 128'd0);
        check_val({tag, " result"}, outs(), exp_o);
        $display("frame %s long=%0d idle=%0d rsp=%h err(t,c,i,e)=%b", tag, lng, idle,
                 bus.response_o, {bus.timeout_err_o, bus.crc_err_o, bus.index_err_o, bus.end_bit_err_o});
        tick();
        check_val({tag, " done pulse"}, 128'(bus.done_o), 128'd0);
        check_val({tag, " hold"}, outs(), exp_o);
    endtask

    initial begin
        logic [135:0] f;
        logic [127:0] cid;
        logic [119:0] content;
        logic [5:0]   idx, expi;
        bit           lng, trans, endb, ci, cc, stuck, noise;
        int           crc_ov, idle;

        bus.sd_clk_en_i = 1'b0; bus.sd_cmd_i = 1'b1; bus.start_i = 1'b0; bus.long_i = 1'b0;
        bus.exp_index_i = '0;   bus.check_index_i = 1'b0; bus.check_crc_i = 1'b0; bus.abort_i = 1'b0;
        repeat (3) tick();
        check_val("reset outs", outs(), 128'd0);
        check_val("reset busy/done", 128'({bus.busy_o, bus.done_o}), 128'd0);
        rst_ni = 1'b1;
        tick();

        f = make_frame(1'b0, 6'd12, '0, 1'b0, 1'b1, 'h7A);
        run_frame("t1 idx12", 1'b0, f, 6'd12, 1'b1, 1'b1, 0, 1'b1, -1, -1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            f = make_frame(1'b0, 6'd0, '0, 1'b0, 1'b1, 0);
            run_frame("t2 idx0", 1'b0, f, 6'd0, 1'b1, 1'b1, i, 1'(i), -1, -1, 1'b0);
        end

        f = make_frame(1'b0, 6'h3F, '0, 1'b0, 1'b1, 'h7F);
        run_frame("t3 chk on", 1'b0, f, 6'd12, 1'b1, 1'b1, 0, 1'b0, -1, -1, 1'b0);
        run_frame("t3 chk off", 1'b0, f, 6'd12, 1'b0, 1'b0, 0, 1'b1, -1, -1, 1'b0);

        f = make_frame(1'b0, 6'd12, 120'h1234_5678, 1'b0, 1'b1, -1);
        run_frame("t4 timeout", 1'b0, f, 6'd12, 1'b1, 1'b1, 64, 1'b0, -1, -1, 1'b0);
        run_frame("t4 start@63", 1'b0, f, 6'd12, 1'b1, 1'b1, 62, 1'b0, -1, -1, 1'b0);

        cid = 128'h03534453443033328012345678016300;
        f = make_frame(1'b1, 6'd0, cid[127:8], 1'b0, 1'b1, -1);
        run_frame("t5 r2 cid", 1'b1, f, 6'd12, 1'b1, 1'b1, 1, 1'b0, -1, -1, 1'b0);
        f = make_frame(1'b1, 6'd0, cid[127:8], 1'b0, 1'b0, -1);
        run_frame("t5 r2 end0", 1'b1, f, 6'd12, 1'b1, 1'b1, 0, 1'b1, -1, -1, 1'b0);

        f = make_frame(1'b0, 6'd17, 120'hDEAD_BEEF, 1'b0, 1'b1, -1);
        run_frame("t6 abort@20", 1'b0, f, 6'd17, 1'b1, 1'b1, 2, 1'b0, 20, -1, 1'b0);
        run_frame("t6 after abort", 1'b0, f, 6'd17, 1'b1, 1'b1, 2, 1'b0, -1, -1, 1'b0);
        run_frame("t6 abort@end", 1'b0, f, 6'd17, 1'b1, 1'b1, 0, 1'b1, 47, -1, 1'b0);
        run_frame("t6 reset@30", 1'b0, f, 6'd17, 1'b1, 1'b1, 0, 1'b0, -1, 30, 1'b0);
        run_frame("t6 after reset", 1'b0, f, 6'd17, 1'b1, 1'b1, 0, 1'b1, -1, -1, 1'b0);

        bus.start_i = 1'b1; bus.abort_i = 1'b1;
        tick();
        bus.start_i = 1'b0; bus.abort_i = 1'b0;
        check_val("start+abort idle", 128'(bus.busy_o), 128'd0);
        tick();

        for (int n = 0; n < 24; n++) begin
            lng     = ($urandom_range(0, 3) == 0);
            idx     = 6'($urandom);
            content = 120'({$urandom, $urandom, $urandom, $urandom});
            trans   = ($urandom_range(0, 7) == 0);
            endb    = ($urandom_range(0, 7) != 0);
            crc_ov  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : -1;
            expi    = $urandom_range(0, 1) ? idx : 6'($urandom);
            ci      = 1'($urandom);
            cc      = 1'($urandom);
            stuck   = 1'($urandom);
            noise   = 1'($urandom);
            case ($urandom_range(0, 5))
                0:       idle = int'($urandom_range(64, 70));
                1:       idle = 62;
                default: idle = int'($urandom_range(0, 5));
            endcase
            f = make_frame(lng, idx, content, trans, endb, crc_ov);
            run_frame("rand", lng, f, expi, ci, cc, idle, stuck, -1, -1, noise);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
